// File: rtl/pb_sw_conditioner_if.sv
// pb_sw_conditioner_if
// Pin-side bundle for the pushbutton/switch conditioner.
//   PB, SW          raw asynchronous board inputs (PB: 1 = pressed)
//   PB_STATE        debounced button levels
//   PB_PRESS        one-cycle pulse on a debounced button 0->1
//   PB_RELEASE      one-cycle pulse on a debounced button 1->0
//   PB_LONG         one-cycle pulse once a press has been held long enough
//   SW_STATE        debounced switch levels
//   SW_CHANGE       one-cycle pulse on any debounced switch transition
//   PRESS_COUNT     PB[0] presses modulo 4, cleared by a PB[1] press
// master: drives the raw pins and observes the conditioned outputs.
// slave:  the conditioner itself.
interface pb_sw_conditioner_if;
  logic [1:0] PB;
  logic [1:0] SW;
  logic [1:0] PB_STATE;
  logic [1:0] PB_PRESS;
  logic [1:0] PB_RELEASE;
  logic [1:0] PB_LONG;
  logic [1:0] SW_STATE;
  logic [1:0] SW_CHANGE;
  logic [1:0] PRESS_COUNT;

  modport master (
    output PB, SW,
    input  PB_STATE, PB_PRESS, PB_RELEASE, PB_LONG,
    input  SW_STATE, SW_CHANGE, PRESS_COUNT
  );

  modport slave (
    input  PB, SW,
    output PB_STATE, PB_PRESS, PB_RELEASE, PB_LONG,
    output SW_STATE, SW_CHANGE, PRESS_COUNT
  );
endinterface

// File: rtl/pb_sw_conditioner.sv
// pb_sw_conditioner
// Turns the two raw pushbuttons and two raw slide switches into synchronised,
// debounced levels plus single-cycle event pulses (press, release, long-press,
// switch change) and keeps a wrapping 2-bit count of PB[0] presses.
// Ports:
//   OSC_FPGA  system clock, all logic on its rising edge
//   RST       synchronous active-high reset
//   io        pb_sw_conditioner_if.slave (raw pins in, conditioned outputs)
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a level change (>= 2)
//   HOLD_CYCLES      cycles of held press before PB_LONG (> DEBOUNCE_CYCLES)
module pb_sw_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000
) (
  input  logic                    OSC_FPGA,
  input  logic                    RST,
  pb_sw_conditioner_if.slave      io
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_CYCLES);

  // Channel order: 0 = PB0, 1 = PB1, 2 = SW0, 3 = SW1.
  logic [3:0] raw;
  logic [3:0] stable;
  logic [1:0] rise;
  logic [1:0] fall;
  logic [1:0] change;
  logic [1:0] press_d;
  logic [1:0] long_pulse;
  logic [1:0] count_q, count_d;

  assign raw = {io.SW, io.PB};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chan
      logic          s1_q, s2_q;
      logic          stable_q, stable_d;
      logic          rise_d, fall_d;
      logic [DW-1:0] cnt_q, cnt_d;

      // Any return of s2 to the accepted level restarts the count, so only
      // an uninterrupted run of DEBOUNCE_CYCLES differing samples is accepted.
      always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (s2_q == stable_q) begin
          cnt_d = '0;
        end else if (cnt_q == DB_LAST) begin
          stable_d = s2_q;
          cnt_d    = '0;
          rise_d   = s2_q;
          fall_d   = ~s2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge OSC_FPGA) begin
        if (RST) begin
          s1_q     <= 1'b0;
          s2_q     <= 1'b0;
          stable_q <= 1'b0;
          cnt_q    <= '0;
        end else begin
          s1_q     <= raw[gi];
          s2_q     <= s1_q;
          stable_q <= stable_d;
          cnt_q    <= cnt_d;
        end
      end

      assign stable[gi] = stable_q;

      if (gi < 2) begin : g_btn
        logic rise_q, fall_q;
        always_ff @(posedge OSC_FPGA) begin
          if (RST) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
          end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
          end
        end
        assign rise[gi]    = rise_q;
        assign fall[gi]    = fall_q;
        // Same-cycle view of the press so PRESS_COUNT moves with PB_PRESS.
        assign press_d[gi] = rise_d;
      end else begin : g_sw
        logic chg_q;
        always_ff @(posedge OSC_FPGA) begin
          if (RST) chg_q <= 1'b0;
          else     chg_q <= rise_d | fall_d;
        end
        assign change[gi-2] = chg_q;
      end
    end

    // Hold counter runs from the cycle after the press; it parks at
    // HOLD_CYCLES so the long-press compare matches only once per press.
    for (gi = 0; gi < 2; gi++) begin : g_hold
      logic [HW-1:0] hold_q;
      logic          long_q;
      always_ff @(posedge OSC_FPGA) begin
        if (RST) begin
          hold_q <= '0;
          long_q <= 1'b0;
        end else if (!stable[gi]) begin
          hold_q <= '0;
          long_q <= 1'b0;
        end else begin
          long_q <= (hold_q == HOLD_LAST);
          if (hold_q != HOLD_SAT) hold_q <= hold_q + 1'b1;
        end
      end
      assign long_pulse[gi] = long_q;
    end
  endgenerate

  // PB1 press clears the count and takes priority over a coincident PB0 press.
  always_comb begin
    count_d = count_q;
    if (press_d[1])      count_d = 2'd0;
    else if (press_d[0]) count_d = count_q + 2'd1;
  end

  always_ff @(posedge OSC_FPGA) begin
    if (RST) count_q <= 2'd0;
    else     count_q <= count_d;
  end

  assign io.PB_STATE    = stable[1:0];
  assign io.SW_STATE    = stable[3:2];
  assign io.PB_PRESS    = rise;
  assign io.PB_RELEASE  = fall;
  assign io.PB_LONG     = long_pulse;
  assign io.SW_CHANGE   = change;
  assign io.PRESS_COUNT = count_q;

endmodule

// File: tb/tb_pb_sw_conditioner.sv
// tb_pb_sw_conditioner
// Directed bench for pb_sw_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=16.
// A vector table covers the clean press/release and bounce timing cycle by
// cycle; hand-written sequences cover counting, long press, simultaneous
// presses, inputs held through reset and reset during a debounce.
module tb_pb_sw_conditioner;
  localparam int DB   = 4;
  localparam int HOLD = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pb_sw_conditioner_if bus();

  pb_sw_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .OSC_FPGA(clk),
    .RST(rst),
    .io(bus)
  );

  int checks = 0;
  int errors = 0;

  // exp layout: {PB_STATE, PB_PRESS, PB_RELEASE, PB_LONG, SW_STATE, SW_CHANGE, PRESS_COUNT}
  typedef struct {
    logic [1:0]  pb;
    logic [13:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [13:0] outs();
    return {bus.PB_STATE, bus.PB_PRESS, bus.PB_RELEASE, bus.PB_LONG,
            bus.SW_STATE, bus.SW_CHANGE, bus.PRESS_COUNT};
  endfunction

  function automatic void add(input logic [1:0] pb, input logic [1:0] st,
                              input logic [1:0] pr, input logic [1:0] rl,
                              input logic [1:0] cnt);
    vec_t v;
    v.pb  = pb;
    v.exp = {st, pr, rl, 2'b00, 2'b00, 2'b00, cnt};
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Press button b for 'hold' cycles, then release and allow 12 cycles for the
  // release to debounce. Counts pulses on that button and notes their cycles.
  task automatic press_run(input int b, input int hold,
                           output int n_press, output int n_long, output int n_rel,
                           output int press_at, output int long_at);
    n_press = 0; n_long = 0; n_rel = 0; press_at = -1; long_at = -1;
    bus.PB[b] = 1'b1;
    for (int c = 0; c < hold + 12; c++) begin
      if (c == hold) bus.PB[b] = 1'b0;
      tick();
      if (bus.PB_PRESS[b])   begin n_press++; if (press_at < 0) press_at = c; end
      if (bus.PB_LONG[b])    begin n_long++;  if (long_at < 0)  long_at  = c; end
      if (bus.PB_RELEASE[b]) n_rel++;
    end
    $display("press pb%0d hold=%0d presses=%0d longs=%0d releases=%0d count=%0d",
             b, hold, n_press, n_long, n_rel, bus.PRESS_COUNT);
  endtask

  initial begin
    int np, nl, nr, pa, la, lat;
    logic [1:0] pv, chg, st;

    // Vector table (edge i samples pb of vector i; exp is seen after edge i).
    for (int i = 0; i < 5; i++) add(2'b01, 2'b00, 2'b00, 2'b00, 2'd0);
    add(2'b01, 2'b01, 2'b01, 2'b00, 2'd1);                               // v5 press
    add(2'b01, 2'b01, 2'b00, 2'b00, 2'd1);
    for (int i = 0; i < 5; i++) add(2'b00, 2'b01, 2'b00, 2'b00, 2'd1);   // v7..v11
    add(2'b00, 2'b00, 2'b00, 2'b01, 2'd1);                               // v12 release
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'd1);
    add(2'b01, 2'b00, 2'b00, 2'b00, 2'd1);                               // bounce 1,0,1,0
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'd1);
    add(2'b01, 2'b00, 2'b00, 2'b00, 2'd1);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'd1);
    for (int i = 0; i < 5; i++) add(2'b01, 2'b00, 2'b00, 2'b00, 2'd1);   // v18..v22
    add(2'b01, 2'b01, 2'b01, 2'b00, 2'd2);                               // v23 press
    add(2'b01, 2'b01, 2'b00, 2'b00, 2'd2);
    for (int i = 0; i < 5; i++) add(2'b00, 2'b01, 2'b00, 2'b00, 2'd2);   // v25..v29
    add(2'b00, 2'b00, 2'b00, 2'b01, 2'd2);                               // v30 release
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'd2);

    // Reset, then idle with all inputs low.
    rst = 1'b1; bus.PB = 2'b00; bus.SW = 2'b00;
    repeat (3) tick();
    check("reset_outs", 32'(outs()), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_outs", 32'(outs()), 32'h0);
    end
    $display("idle 20 cycles outs=%h", outs());

    foreach (vecs[i]) begin
      bus.PB = vecs[i].pb;
      tick();
      $display("vec %0d pb=%b outs=%h exp=%h", i, vecs[i].pb, outs(), vecs[i].exp);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // PB1 press clears the count.
    press_run(1, 8, np, nl, nr, pa, la);
    check("pb1_clear_press", 32'(np), 32'd1);
    check("pb1_clear_count", 32'(bus.PRESS_COUNT), 32'd0);
    check("pb1_clear_release", 32'(nr), 32'd1);

    // Five presses of PB0: 1,2,3,0,1.
    for (int k = 0; k < 5; k++) begin
      press_run(0, 8, np, nl, nr, pa, la);
      check($sformatf("count_press%0d_pulses", k), 32'(np), 32'd1);
      check($sformatf("count_press%0d", k), 32'(bus.PRESS_COUNT), 32'((k + 1) % 4));
    end
    press_run(1, 8, np, nl, nr, pa, la);
    check("pb1_count_clear", 32'(bus.PRESS_COUNT), 32'd0);

    // Long press on PB1 held 40 cycles.
    press_run(1, 40, np, nl, nr, pa, la);
    check("long_press_pulses", 32'(np), 32'd1);
    check("long_pulses", 32'(nl), 32'd1);
    check("long_delay", 32'(la - pa), 32'(HOLD));
    check("long_release", 32'(nr), 32'd1);

    // Short press must not produce a long pulse.
    press_run(0, 8, np, nl, nr, pa, la);
    check("short_no_long", 32'(nl), 32'd0);
    press_run(0, 8, np, nl, nr, pa, la);
    check("pre_simul_count", 32'(bus.PRESS_COUNT), 32'd2);

    // Both buttons on the same edge with count 2: clear wins.
    bus.PB = 2'b11;
    pv = 2'b00;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus.PB_PRESS != 2'b00 && pv == 2'b00) pv = bus.PB_PRESS;
    end
    $display("simultaneous press pulses=%b count=%0d", pv, bus.PRESS_COUNT);
    check("simul_press", 32'(pv), 32'h3);
    check("simul_count", 32'(bus.PRESS_COUNT), 32'd0);
    bus.PB = 2'b00;
    repeat (12) tick();

    // Switches held high through reset.
    bus.SW = 2'b11;
    rst = 1'b1;
    repeat (3) tick();
    check("sw_reset_outs", 32'(outs()), 32'h0);
    rst = 1'b0;
    lat = -1; chg = 2'b00; st = 2'b00;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (bus.SW_CHANGE != 2'b00 && lat < 0) begin
        lat = c; chg = bus.SW_CHANGE; st = bus.SW_STATE;
      end
    end
    $display("sw through reset latency=%0d change=%b state=%b", lat, chg, st);
    check("sw_latency", 32'(lat), 32'(DB + 2));
    check("sw_change", 32'(chg), 32'h3);
    check("sw_state", 32'(st), 32'h3);

    // Reset two cycles into a SW[0] debounce.
    bus.SW = 2'b10;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("abort_pre_change", 32'(bus.SW_CHANGE), 32'h0);
    end
    rst = 1'b1; bus.SW = 2'b00;
    tick();
    check("abort_in_reset", 32'(outs()), 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("abort_after", 32'(outs()), 32'h0);
    end
    $display("abort sequence outs=%h", outs());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
